// File: rtl/booth_arith_unit.sv
// booth_arith_unit: exact signed add/sub path plus a sequential radix-2 Booth multiplier.
module booth_arith_unit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 op,
  output logic [WIDTH:0]       z,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   outbus,
  output logic                 done,
  output logic                 busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t               state_q;
  logic [WIDTH-1:0]     m_q, q_q, q_d;
  logic [WIDTH:0]       a_q, a_d, a_sum, m_ext;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   outbus_q;
  logic                 done_q, busy_q;
  logic [2*WIDTH+1:0]   sh;
  assign z = op ? {x[WIDTH-1], x} - {y[WIDTH-1], y} : {x[WIDTH-1], x} + {y[WIDTH-1], y};
  assign m_ext = {m_q[WIDTH-1], m_q};
  // A carries one guard bit so that subtracting the most negative M stays exact
  always_comb begin
    a_sum = ({q_q[0], qm1_q} == 2'b01) ? a_q + m_ext :
            ({q_q[0], qm1_q} == 2'b10) ? a_q - m_ext : a_q;
  end
  assign sh = $signed({a_sum, q_q, qm1_q}) >>> 1;
  assign {a_d, q_d, qm1_d} = sh;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      outbus_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      m_q      <= '0;
      q_q      <= '0;
      a_q      <= '0;
      qm1_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q     <= multiplicand;
            q_q     <= multiplier;
            a_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          a_q   <= a_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            outbus_q <= {a_d[WIDTH-1:0], q_d};
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE: begin
          // a held start must not retrigger; wait for it to drop first
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign outbus = outbus_q;
  assign done   = done_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_booth_arith_unit.sv
// tb_booth_arith_unit: randomized and directed checks of booth_arith_unit against plain-arithmetic expectations.
module tb_booth_arith_unit;
  localparam int W = 8;
  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   x, y;
  logic           op;
  logic [W:0]     z;
  logic           start;
  logic [W-1:0]   multiplicand, multiplier;
  logic [2*W-1:0] outbus;
  logic           done, busy;
  int checks = 0;
  int failures = 0;

  booth_arith_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .op(op), .z(z),
    .start(start), .multiplicand(multiplicand), .multiplier(multiplier),
    .outbus(outbus), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_vec(input logic signed [W-1:0] a, input logic signed [W-1:0] b, input logic o);
    int s;
    logic [W:0] e;
    s = o ? int'(a) - int'(b) : int'(a) + int'(b);
    e = s[W:0];
    x = a; y = b; op = o;
    #1;
    chk("z", 32'(z), 32'(e));
  endtask

  task automatic do_mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                        input bit scramble, input bit hold);
    int p;
    logic [2*W-1:0] e;
    p = int'(a) * int'(b);
    e = p[2*W-1:0];
    @(negedge clk);
    multiplicand = a; multiplier = b; start = 1'b1;
    @(negedge clk);
    if (scramble) begin
      multiplicand = ~a;
      multiplier = a ^ b ^ 8'h5a;
    end
    chk("busy_e0", 32'(busy), 32'd1);
    chk("done_e0", 32'(done), 32'd0);
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      chk("busy_step", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("done", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("product", 32'(outbus), 32'(e));
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_prod", 32'(outbus), 32'(e));
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_prod", 32'(outbus), 32'(e));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x = '0; y = '0; op = 1'b0;
    multiplicand = '0; multiplier = '0;
    repeat (2) @(negedge clk);
    chk("rst_outbus", 32'(outbus), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    add_vec(8'sd127, 8'sd127, 1'b0);
    add_vec(-8'sd128, 8'sd127, 1'b1);
    add_vec(8'sd5, -8'sd3, 1'b0);
    add_vec(-8'sd128, -8'sd128, 1'b0);
    add_vec(8'sd127, -8'sd128, 1'b1);
    for (int i = 0; i < 40; i++)
      add_vec(W'($urandom), W'($urandom), 1'($urandom));
    do_mul(8'sd7, -8'sd3, 1'b0, 1'b0);
    do_mul(-8'sd128, -8'sd128, 1'b0, 1'b0);
    do_mul(-8'sd128, 8'sd127, 1'b0, 1'b0);
    do_mul(8'sd0, -8'sd128, 1'b0, 1'b0);
    do_mul(-8'sd1, -8'sd1, 1'b0, 1'b0);
    do_mul(8'sd100, 8'sd3, 1'b0, 1'b1);
    do_mul(8'sd12, 8'sd12, 1'b0, 1'b0);
    do_mul(-8'sd77, 8'sd45, 1'b1, 1'b0);
    do_mul(8'sd127, 8'sd127, 1'b1, 1'b0);
    @(negedge clk);
    multiplicand = 8'sd50; multiplier = -8'sd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outbus", 32'(outbus), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle_busy", 32'(busy), 32'd0);
    do_mul(8'sd10, -8'sd10, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      do_mul(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
